aes_inv_cipher_ctrl: RTL and testbench

- Iterative AES-128 inverse-cipher controller: sequences one decryption round per clock over a single 128-bit state register.
- Instantiates the shared 16-byte inverse S-box bank plus InvShiftRows, InvMixColumns and AddRoundKey logic.
- Fetches round keys from the key-schedule block over a req/valid handshake.
- Delivers plaintext over a valid/ready handshake.
- Sits between the ciphertext input buffer and the plaintext output FIFO in the decrypt path.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes_inv_cipher_ctrl_if.sv | 26 ++
 rtl/inv_s_box_16.sv | 31 +++
 rtl/aes_inv_cipher_ctrl.sv | 96 +++++++++
 tb/tb_aes_inv_cipher_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and the inverse round-transform helpers.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  localparam int AES128_NR = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WHITEN = 3'd1,
    ROUND  = 3'd2,
    FINAL  = 3'd3,
    DONE   = 3'd4
  } dec_ctrl_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
  function automatic aes_state_t inv_shift_rows(input aes_state_t s);
    aes_state_t r;
    int row, col, src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      row = i % 4;
      col = i / 4;
      src = 4 * ((col - row + 4) % 4) + row;
      r[127-8*i -: 8] = s[127-8*src -: 8];
    end
    return r;
  endfunction

  // Column-wise multiply by the {0e,0b,0d,09} circulant.
  function automatic aes_state_t inv_mix_columns(input aes_state_t s);
    aes_state_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// Host / key-schedule / output handshake bundle for the inverse-cipher controller.
interface aes_inv_cipher_ctrl_if;
  import aes_pkg::*;

  logic       start;
  aes_state_t ct_in;
  logic       busy;
  logic       rk_req;
  logic [3:0] rk_idx;
  logic       rk_valid;
  aes_state_t rk_data;
  aes_state_t pt_out;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output start, ct_in, rk_valid, rk_data, out_ready,
    input  busy, rk_req, rk_idx, pt_out, out_valid
  );

  modport slave (
    input  start, ct_in, rk_valid, rk_data, out_ready,
    output busy, rk_req, rk_idx, pt_out, out_valid
  );

endinterface

// File: rtl/inv_s_box_16.sv
// Sixteen parallel AES inverse S-boxes: inverse affine map, then GF(2^8) inverse.
module inv_s_box_16
  import aes_pkg::*;
(
  input  aes_state_t din,
  output aes_state_t dout
);

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, s;
    p = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout[8*i +: 8] = inv_sbox(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse cipher: one round per acknowledged key fetch over one state register.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_cipher_ctrl_if.slave bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  dec_ctrl_state_t st_q;
  aes_state_t      state_q;
  aes_state_t      isr, isb, ark;
  logic [3:0]      round_q;
  logic            busy_q, rk_req_q, out_valid_q;
  logic [3:0]      rk_idx_q;
  logic            step, accept;

  assign isr = inv_shift_rows(state_q);

  inv_s_box_16 u_isb (
    .din  (isr),
    .dout (isb)
  );

  assign ark    = isb ^ bus.rk_data;
  assign step   = rk_req_q & bus.rk_valid;
  assign accept = bus.start & ((st_q == IDLE) | ((st_q == DONE) & bus.out_ready));

  assign bus.busy      = busy_q;
  assign bus.rk_req    = rk_req_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pt_out    = state_q;

  // Sequencer and datapath; key-side outputs are registered so they stay put through waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      state_q     <= '0;
      round_q     <= '0;
      busy_q      <= 1'b0;
      rk_req_q    <= 1'b0;
      rk_idx_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE, DONE: begin
          if (accept) begin
            st_q        <= WHITEN;
            state_q     <= bus.ct_in;
            round_q     <= NR_IDX;
            busy_q      <= 1'b1;
            rk_req_q    <= 1'b1;
            rk_idx_q    <= NR_IDX;
            out_valid_q <= 1'b0;
          end else if (st_q == DONE && bus.out_ready) begin
            st_q        <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        WHITEN: begin
          if (step) begin
            st_q     <= ROUND;
            state_q  <= state_q ^ bus.rk_data;
            round_q  <= NR_IDX - 4'd1;
            rk_idx_q <= NR_IDX - 4'd1;
          end
        end
        ROUND: begin
          if (step) begin
            state_q  <= inv_mix_columns(ark);
            round_q  <= round_q - 4'd1;
            rk_idx_q <= round_q - 4'd1;
            if (round_q == 4'd1) st_q <= FINAL;
          end
        end
        FINAL: begin
          if (step) begin
            st_q        <= DONE;
            state_q     <= ark;
            busy_q      <= 1'b0;
            rk_req_q    <= 1'b0;
            rk_idx_q    <= '0;
            out_valid_q <= 1'b1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: known-answer table, key stalls, backpressure, back-to-back, reset.
module tb_aes_inv_cipher_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_inv_cipher_ctrl_if bus ();

  aes_inv_cipher_ctrl #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           duty;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  int           checks = 0;
  int           errors = 0;
  logic [127:0] rk [16];
  logic [127:0] exp_q [$];
  logic         ov_prev = 1'b0;
  vec_t         vt [6];

  // Key-schedule responder: combinational lookup of the requested round key.
  assign bus.rk_data = rk[bus.rk_idx];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] tb_xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) r = r ^ x;
      x = tb_xt(x);
      y = y >> 1;
    end
    return r;
  endfunction

  // Forward S-box by brute-force inverse search plus the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    for (int y = 1; y < 256; y++)
      if (tb_mul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = tb_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Called at a negedge in IDLE: present one block and queue its plaintext.
  task automatic start_blk(input logic [127:0] ct, input logic [127:0] pt);
    bus.ct_in = ct;
    bus.start = 1'b1;
    exp_q.push_back(pt);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the negedge after start was sampled; follows the key fetches until done.
  task automatic follow(input int duty, input bit noise);
    int         edges   = 0;
    int         stalls  = 0;
    int         exp_idx = 10;
    logic [3:0] ei;
    bit         rv;
    while (!bus.out_valid && edges < 300) begin
      ei = exp_idx[3:0];
      chk("busy_in_flight", bus.busy, 1'b1);
      chk("rk_req_held", bus.rk_req, 1'b1);
      chk("rk_idx_seq", bus.rk_idx, ei);
      rv = ($urandom_range(99) < duty);
      bus.rk_valid = rv;
      if (noise) begin
        bus.start = 1'($urandom_range(1));
        bus.ct_in = {4{$urandom()}};
      end
      if (rv) exp_idx--;
      else stalls++;
      @(negedge clk);
      edges++;
    end
    bus.start = 1'b0;
    chk("out_valid_seen", bus.out_valid, 1'b1);
    chk("latency", edges, 11 + stalls);
    chk("keys_used", 10 - exp_idx, 11);
    chk("busy_done", bus.busy, 1'b0);
  endtask

  // Scoreboard: every rising out_valid must match the oldest queued plaintext.
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !ov_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got pt %h expected no result", bus.pt_out);
        end else begin
          e = exp_q.pop_front();
          chk("pt_out", bus.pt_out, e);
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.ct_in     = '1;
    bus.rk_valid  = 1'b1;
    bus.out_ready = 1'b1;

    expand(C1_KEY);
    chk("model_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset dominates an asserted start.
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rk_req", bus.rk_req, 1'b0);
    chk("rst_rk_idx", bus.rk_idx, 4'd0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_pt_out", bus.pt_out, 128'h0);
    rst       = 1'b0;
    bus.start = 1'b0;

    // Key acks while idle do nothing.
    for (int i = 0; i < 4; i++) begin
      bus.rk_valid = 1'($urandom_range(1));
      @(negedge clk);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_rk_req", bus.rk_req, 1'b0);
      chk("idle_out_valid", bus.out_valid, 1'b0);
    end

    // Known-answer table, each vector with and without key stalls.
    vt[0] = '{C1_KEY, C1_CT, C1_PT, 100};
    vt[1] = '{C1_KEY, C1_CT, C1_PT, 40};
    vt[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 100};
    vt[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 40};
    vt[4] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 100};
    vt[5] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 40};
    for (int v = 0; v < 6; v++) begin
      expand(vt[v].key);
      start_blk(vt[v].ct, vt[v].pt);
      follow(vt[v].duty, 1'b0);
      @(negedge clk);
      chk("back_to_idle", bus.out_valid, 1'b0);
    end

    // Output backpressure: result held, start ignored, IDLE one edge after out_ready.
    expand(C1_KEY);
    bus.out_ready = 1'b0;
    start_blk(C1_CT, C1_PT);
    follow(100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.start = (i % 2 == 0);
      bus.ct_in = {4{$urandom()}};
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_pt_out", bus.pt_out, C1_PT);
      chk("bp_busy", bus.busy, 1'b0);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", bus.out_valid, 1'b0);
    chk("bp_release_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk("bp_stays_idle", bus.busy, 1'b0);

    // Back-to-back: new block accepted in the DONE cycle, no idle bubble.
    bus.out_ready = 1'b0;
    start_blk(C1_CT, C1_PT);
    follow(100, 1'b0);
    bus.out_ready = 1'b1;
    bus.ct_in     = C1_CT;
    bus.start     = 1'b1;
    exp_q.push_back(C1_PT);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1'b1);
    chk("b2b_out_valid", bus.out_valid, 1'b0);
    follow(100, 1'b0);
    @(negedge clk);

    // Reset mid-operation abandons the block with no result.
    bus.ct_in    = C1_CT;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rk_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_rk_req", bus.rk_req, 1'b0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_pt_out", bus.pt_out, 128'h0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", bus.out_valid, 1'b0);
    end
    start_blk(C1_CT, C1_PT);
    follow(100, 1'b0);
    @(negedge clk);

    // Start pulses and ct_in churn while busy do not disturb the block.
    start_blk(C1_CT, C1_PT);
    follow(60, 1'b1);
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_valid", bus.out_valid, 1'b0);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
